// File: rtl/ro_pkg.sv
// ro_pkg: shared constants, event type and helpers for the readout event capture
package ro_pkg;

  localparam int CH_W     = 5;
  localparam int TS_W_DEF = 19;

  // Event record at the default timestamp width; the top builds its own
  // record with the same layout for a non-default TS_W.
  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic                pol;
    logic [TS_W_DEF-1:0] ts;
  } ro_event_t;

  // Index of the lowest set bit: the gray-counter bit that toggles in this cycle.
  function automatic logic [CH_W-1:0] ctz(input logic [31:0] v);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) r = CH_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/ro_event_fifo.sv
// ro_event_fifo: first-word-fall-through FIFO with extra-bit pointer wrap
module ro_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk_master,
  input  logic         rstb,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  // Flags, pointer advance and write; a push into a full FIFO is accepted when a pop frees the slot.
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
    dout    = mem_q[rd_q[AW-1:0]];
  end

  // Storage and pointers; reset discards all contents.
  always_ff @(posedge clk_master or negedge rstb)
    if (!rstb) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end

endmodule

// File: rtl/ro_event_capture.sv
// ro_event_capture: tracks bus slot ownership, captures readout events and buffers them
module ro_event_capture
  import ro_pkg::*;
#(
  parameter int N_CH       = 19,
  parameter int TS_W       = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk_master,
  input  logic            rstb,
  input  logic            rd_eve,
  input  logic            rd_pol,
  input  logic            ev_ready,
  input  logic            clr_ovf,
  output logic            ev_valid,
  output logic [CH_W-1:0] ev_ch,
  output logic            ev_pol,
  output logic [TS_W-1:0] ev_ts,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            pol;
    logic [TS_W-1:0] ts;
  } ev_t;

  logic [TS_W-1:0] cnt_q, cnt_d;
  logic            first_q, first_d;
  logic            slot_own;
  logic [CH_W-1:0] slot_ch;
  logic            cap_vld_q, cap_vld_d;
  ev_t             cap_ev_q, cap_ev_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic            drop, pop, full, empty;
  ev_t             head;

  // Slot owner: the toggling gray bit; a zero count after a wrap belongs to the MSB, the first cycle after reset to nobody.
  always_comb begin
    cnt_d    = cnt_q + TS_W'(1);
    first_d  = 1'b0;
    slot_own = !first_q;
    slot_ch  = (cnt_q == '0) ? CH_W'(TS_W - 1) : ctz(32'(cnt_q));
    cap_vld_d = slot_own && (int'(slot_ch) < N_CH) && rd_eve;
    cap_ev_d  = {slot_ch, rd_pol, cnt_q};
  end

  // Bus is sampled mid-cycle, while the owner still drives it, together with the slot tag.
  always_ff @(negedge clk_master or negedge rstb)
    if (!rstb) begin
      cap_vld_q <= 1'b0;
      cap_ev_q  <= '0;
    end else begin
      cap_vld_q <= cap_vld_d;
      cap_ev_q  <= cap_ev_d;
    end

  // Drop only when full with no simultaneous pop; a drop beats a same-edge clear.
  always_comb begin
    pop    = ev_ready && !empty;
    drop   = cap_vld_q && full && !pop;
    ovf_d  = drop || (ovf_q && !clr_ovf);
    drop_d = drop ? (clr_ovf ? 8'd1 : drop_q + {7'd0, drop_q != 8'hff}) : (clr_ovf ? 8'd0 : drop_q);
  end

  // Slot counter, first-cycle flag and overflow bookkeeping.
  always_ff @(posedge clk_master or negedge rstb)
    if (!rstb) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end

  ro_event_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ev_t))) u_fifo (
    .clk_master(clk_master),
    .rstb      (rstb),
    .push      (cap_vld_q),
    .din       (cap_ev_q),
    .pop       (ev_ready),
    .dout      (head),
    .full      (full),
    .empty     (empty)
  );

  assign ev_valid = !empty;
  assign ev_ch    = head.ch;
  assign ev_pol   = head.pol;
  assign ev_ts    = head.ts;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_ro_event_capture.sv
// tb_ro_event_capture: three parameterisations driven by one bus, checked against a queue model
module tb_ro_event_capture;

  localparam int NI = 3;
  localparam int FD = 8;

  logic clk, rstb, rd_eve, rd_pol, ev_ready, clr_ovf;
  logic [2:0]  v, pl, ov;
  logic [4:0]  ch0, ch1, ch2;
  logic [18:0] ts0;
  logic [3:0]  ts1, ts2;
  logic [7:0]  dc0, dc1, dc2;
  int a_ch[NI], a_ts[NI], a_dc[NI];

  ro_event_capture #(.N_CH(19), .TS_W(19), .FIFO_DEPTH(FD)) u0 (
    .clk_master(clk), .rstb(rstb), .rd_eve(rd_eve), .rd_pol(rd_pol), .ev_ready(ev_ready),
    .clr_ovf(clr_ovf), .ev_valid(v[0]), .ev_ch(ch0), .ev_pol(pl[0]), .ev_ts(ts0),
    .overflow(ov[0]), .drop_cnt(dc0));
  ro_event_capture #(.N_CH(4), .TS_W(4), .FIFO_DEPTH(FD)) u1 (
    .clk_master(clk), .rstb(rstb), .rd_eve(rd_eve), .rd_pol(rd_pol), .ev_ready(ev_ready),
    .clr_ovf(clr_ovf), .ev_valid(v[1]), .ev_ch(ch1), .ev_pol(pl[1]), .ev_ts(ts1),
    .overflow(ov[1]), .drop_cnt(dc1));
  ro_event_capture #(.N_CH(3), .TS_W(4), .FIFO_DEPTH(FD)) u2 (
    .clk_master(clk), .rstb(rstb), .rd_eve(rd_eve), .rd_pol(rd_pol), .ev_ready(ev_ready),
    .clr_ovf(clr_ovf), .ev_valid(v[2]), .ev_ch(ch2), .ev_pol(pl[2]), .ev_ts(ts2),
    .overflow(ov[2]), .drop_cnt(dc2));

  always_comb begin
    a_ch[0] = int'(ch0); a_ch[1] = int'(ch1); a_ch[2] = int'(ch2);
    a_ts[0] = int'(ts0); a_ts[1] = int'(ts1); a_ts[2] = int'(ts2);
    a_dc[0] = int'(dc0); a_dc[1] = int'(dc1); a_dc[2] = int'(dc2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int ch; int pol; int ts;} mev_t;
  typedef struct {logic e, p, r, c; logic ev; int ch; int pol; int ts;} vec_t;

  mev_t mq[NI][$];
  int m_ovf[NI], m_dc[NI];
  int slot;
  int n_cmp, n_bad;

  function automatic int nch(int i);
    return (i == 0) ? 19 : ((i == 1) ? 4 : 3);
  endfunction

  function automatic int tsw(int i);
    return (i == 0) ? 19 : 4;
  endfunction

  function automatic int ctz_ref(int c);
    int n = 0;
    while (c % 2 == 0) begin
      c = c / 2;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (slot %0d)", nm, act, exp, slot);
    end
  endtask

  // Reference: which core owns slot k, and what one clock edge does to each instance's queue.
  task automatic model_edge(input logic e, input logic p, input logic r, input logic c);
    for (int i = 0; i < NI; i++) begin
      int tw, ts, ch;
      bit pu, po, dr;
      mev_t ev;
      tw = tsw(i);
      ts = slot % (1 << tw);
      ch = (ts == 0) ? tw - 1 : ctz_ref(ts);
      pu = (slot != 0) && (e === 1'b1) && (ch < nch(i));
      po = r && (mq[i].size() > 0);
      dr = 1'b0;
      if (pu) begin
        if (mq[i].size() == FD && !po) dr = 1'b1;
        else begin
          ev.ch = ch; ev.pol = int'(p); ev.ts = ts;
          mq[i].push_back(ev);
        end
      end
      if (po) void'(mq[i].pop_front());
      m_ovf[i] = dr ? 1 : (c ? 0 : m_ovf[i]);
      m_dc[i]  = dr ? (c ? 1 : ((m_dc[i] < 255) ? m_dc[i] + 1 : 255)) : (c ? 0 : m_dc[i]);
    end
    slot++;
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("valid%0d", i), int'(v[i]), int'(mq[i].size() > 0));
      if (mq[i].size() > 0) begin
        chk($sformatf("ch%0d", i), a_ch[i], mq[i][0].ch);
        chk($sformatf("pol%0d", i), int'(pl[i]), mq[i][0].pol);
        chk($sformatf("ts%0d", i), a_ts[i], mq[i][0].ts);
      end
      chk($sformatf("ovf%0d", i), int'(ov[i]), m_ovf[i]);
      chk($sformatf("drop%0d", i), a_dc[i], m_dc[i]);
    end
  endtask

  // Inputs for the current slot are set just after its edge, so they are stable across the sampling negedge.
  task automatic step(input logic e, input logic p, input logic r, input logic c);
    rd_eve = e; rd_pol = p; ev_ready = r; clr_ovf = c;
    @(posedge clk);
    #1;
    model_edge(e, p, r, c);
    check_all();
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    rd_eve = 1'b0; rd_pol = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid%0d", i), int'(v[i]), 0);
      chk($sformatf("rst_ovf%0d", i), int'(ov[i]), 0);
      chk($sformatf("rst_drop%0d", i), a_dc[i], 0);
      chk($sformatf("rst_ch%0d", i), a_ch[i], 0);
      chk($sformatf("rst_pol%0d", i), int'(pl[i]), 0);
      chk($sformatf("rst_ts%0d", i), a_ts[i], 0);
    end
    @(posedge clk);
    #1;
    rstb = 1'b1;
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      m_ovf[i] = 0;
      m_dc[i] = 0;
    end
    slot = 0;
  endtask

  initial begin
    vec_t tbl[10];
    int rp;
    n_cmp = 0; n_bad = 0; slot = 0;
    rstb = 1'b1; rd_eve = 1'b0; rd_pol = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    #2;
    do_reset();

    // Continuous events with ready high: owner sequence 0,1,0,2,0,1,0,3,... and no event for slot 0.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 2};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 3};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 4};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 5};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 6};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 7};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 8};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 9};
    for (int j = 0; j < 10; j++) begin
      step(tbl[j].e, tbl[j].p, tbl[j].r, tbl[j].c);
      chk("tbl_valid", int'(v[0]), int'(tbl[j].ev));
      if (tbl[j].ev) begin
        chk("tbl_ch", a_ch[0], tbl[j].ch);
        chk("tbl_pol", int'(pl[0]), tbl[j].pol);
        chk("tbl_ts", a_ts[0], tbl[j].ts);
      end
    end

    // Single event in slot 4 appears after edge 5.
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      step(k == 4, k == 4, 1'b1, 1'b0);
      if (k == 3) chk("single_early", int'(v[0]), 0);
    end
    chk("single_valid", int'(v[0]), 1);
    chk("single_ch", a_ch[0], 2);
    chk("single_pol", int'(pl[0]), 1);
    chk("single_ts", a_ts[0], 4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_gone", int'(v[0]), 0);

    // Overflow: 12 owned slots into an 8-deep FIFO, clear vs drop priority, full push+pop, ordered drain.
    do_reset();
    for (int k = 0; k <= 12; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", int'(ov[0]), 1);
    chk("ovf_drop", a_dc[0], 4);
    chk("ovf_drop_n3", a_dc[2], 3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop_ovf", int'(ov[0]), 1);
    chk("clr_vs_drop_cnt", a_dc[0], 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", int'(ov[0]), 0);
    chk("clr_cnt", a_dc[0], 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("full_pushpop_drop", a_dc[0], 0);
    chk("full_pushpop_head", a_ts[0], 2);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (k < 6) chk("drain_ts", a_ts[0], k + 3);
      else if (k == 6) chk("drain_last", a_ts[0], 15);
      else chk("drain_empty", int'(v[0]), 0);
    end

    // Wrap with a 4-bit counter: slot 16 belongs to channel 3, suppressed when only 3 channels exist.
    do_reset();
    for (int k = 0; k <= 16; k++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("wrap_valid", int'(v[1]), 1);
    chk("wrap_ch", a_ch[1], 3);
    chk("wrap_ts", a_ts[1], 0);
    chk("wrap_suppr", int'(v[2]), 0);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b1, 1'b0);

    // Reset mid-burst with the FIFO half full, then restart from ts 1.
    do_reset();
    for (int k = 0; k <= 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("half_full_head", a_ts[0], 1);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("restart_slot0", int'(v[0]), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("restart_ts", a_ts[0], 1);

    // Drop counter saturation.
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("drop_sat", a_dc[0], 255);

    // Randomised traffic with varying consumer readiness; unowned slot 0 sees undriven lines.
    do_reset();
    rp = 50;
    for (int n = 0; n < 600; n++) begin
      logic e, p, r, c;
      if (n % 100 == 0) rp = $urandom_range(0, 100);
      e = $urandom_range(0, 3) != 0;
      p = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99) < rp;
      c = $urandom_range(0, 49) == 0;
      if (slot == 0) step(1'bx, 1'bx, r, c);
      else step(e, p, r, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ro_event_capture.md
# ro_event_capture

Downstream consumer of the shared readout lines driven by the per-core `ro_block_*` tristate stages. A replica slot counter tracks the master gray counter, so the block knows which core owns the bus in each `clk_master` cycle. Each cycle it samples the two readout lines (`out_mux_eve`, `out_mux_pol_eve`), tags asserted events with channel index and timestamp, and buffers them in a small FIFO. The FIFO drains to the off-chip or digital back-end over a valid/ready interface.

## Interface
- `N_CH`, default 19: number of cores/channels on the bus; must be ≤ `TS_W`.
- `TS_W`, default 19: slot counter width; equals the master gray counter width.
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, ≥ 2.
- `clk_master` input 1: master clock, the single clock; the same clock as the gray counter.
- `rstb` input 1: asynchronous active-low reset; the same net that resets the gray counter.
- `rd_eve` input 1: shared readout line carrying `out_mux_eve`.
- `rd_pol` input 1: shared readout line carrying `out_mux_pol_eve`.
- `ev_ready` input 1: consumer accepts the head event.
- `clr_ovf` input 1: synchronous clear of `overflow` and `drop_cnt`.
- `ev_valid` output 1: FIFO head is valid.
- `ev_ch` output 5: channel index of the head event; core index = `ev_ch`+1.
- `ev_pol` output 1: polarity bit of the head event.
- `ev_ts` output `TS_W`: slot count at capture.
- `overflow` output 1: sticky flag, set when an event is dropped.
- `drop_cnt` output 8: count of dropped events, saturating.

## Operation
- Slot counter `cnt` (binary, `TS_W` bits):
  - 0 on reset; +1 every `clk_master` posedge; wraps from all-ones to 0.
  - Mirrors the gray counter, whose bit `ctz(cnt)` toggles in cycle `cnt`.
- Slot owner:
  - `ch = ctz(cnt)` for `cnt ≠ 0`.
  - `cnt = 0` after a wrap: `ch = TS_W-1`, because the gray MSB toggles.
  - `cnt = 0` in the first cycle after reset: no owner. A `first` flag, set by reset and cleared at the first posedge, marks this case.
- Sampling:
  - `rd_eve` and `rd_pol` are captured at the `clk_master` negedge. The owner drives the bus only during the high phase.
  - The bus must be stable from before the negedge until past it, which relies on the owner's edge-FF reset/tristate release delay.
  - The captured values are held with the slot's `ch`/`cnt`.
- Push decision, made at the following posedge:
  - Push `{ch, pol, ts=cnt_of_slot}` iff the slot had an owner, `ch < N_CH`, and the captured `rd_eve = 1`.
  - No-owner slots, slots with `ch ≥ N_CH`, and captured `rd_eve = 0` produce nothing.
  - X/Z on the lines in an unowned slot is ignored.
- FIFO behaviour:
  - First-word-fall-through.
  - Pop when `ev_valid && ev_ready` at a posedge.
  - Push while full with no pop in the same edge: event dropped, `overflow` ← 1, `drop_cnt` += 1, saturating at 255.
  - Push and pop at the same edge while full: both happen, no drop.
  - Pop while empty: ignored.
- `clr_ovf` behaviour: clears `overflow` and `drop_cnt` at the posedge. If a drop occurs at the same edge, the drop wins: `overflow` = 1, `drop_cnt` = 1.

## Timing
- Reset values: `ev_valid` = 0, `overflow` = 0, `drop_cnt` = 0, `ev_ch`/`ev_pol`/`ev_ts` = 0, `cnt` = 0, FIFO empty, `first` = 1.
- Reset asserted mid-operation: all state is cleared asynchronously and FIFO contents are discarded. The bench must reset the gray counter with the same `rstb`.
- Slot k: posedge k sets `cnt = k`; the bus is sampled at the negedge of cycle k.
- Latency: the entry is written at posedge k+1, and `ev_valid` is high after posedge k+1 (1 cycle from the slot start edge).
- Throughput: at most 1 push per cycle; pushes and pops are sustained indefinitely with `ev_ready = 1` and no drops.
- Outputs are registered or driven directly from FIFO head storage; there is no combinational path from `rd_*` to outputs.

## Structure
- Package `ro_pkg`:
  - `CH_W` = 5.
  - Function `ctz(cnt)` returning `CH_W` bits.
  - Typedef `ro_event_t` = `{ch[CH_W-1:0], pol, ts[TS_W-1:0]}`.
- Sub-module `ro_event_fifo`: parameterised depth and width, FWFT, with `full`/`empty` flags and pointer-based wrap (one extra pointer bit).
- Top level holds the slot counter, the `first` flag, the negedge capture flops, the push decode and the overflow logic.

## Test plan
- Reset then hold `rd_eve` = 1, `rd_pol` = 0 with `ev_ready` = 1 → events arrive with `ch` sequence 0,1,0,2,0,1,0,3… and `ts` = 1,2,3,4…; no event for `ts` = 0.
- Drive `rd_eve` = 1 only in slot 4, with `rd_pol` = 1 → exactly one event `{ch=2, pol=1, ts=4}`; `ev_valid` rises after posedge 5.
- `ev_ready` = 0, `rd_eve` = 1 for 12 owned slots, `FIFO_DEPTH` = 8 → 8 events stored, `overflow` = 1, `drop_cnt` = 4. Then `clr_ovf` → both 0, and the 8 events drain in order.
- `TS_W` = 4: run past a wrap → slot after `cnt` = 15 yields `ch` = 3, `ts` = 0; `N_CH` = 3 suppresses every `ch` = 3 slot.
- Assert `rstb` low mid-burst with the FIFO half full → immediate `ev_valid` = 0 and counters at 0; after release the sequence restarts at `ts` = 1.
- Full FIFO with `ev_ready` = 1 and a push at the same edge → no drop; occupancy stays 8.
